// File: rtl/cla_seq_pkg.sv
// cla_seq_pkg: shared width, FSM states and result-word layout
// for the streamed multi-word CLA adder/subtractor.
package cla_seq_pkg;

  localparam int WIDTH = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             last;
    logic             carry;
  } res_t;

endpackage

// File: rtl/cla_seq_adder_cla16.sv
// cla_seq_adder_cla16: 16-bit carry-lookahead adder,
// four 4-bit groups with a second-level group lookahead.
module cla_seq_adder_cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] s,
  output logic        cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  gg;
  logic [3:0]  pg;
  logic [4:0]  cg;

  assign g = a & b;
  assign p = a ^ b;

  for (genvar k = 0; k < 4; k++) begin : g_grp
    assign gg[k] = g[4*k+3]
                 | (p[4*k+3] & g[4*k+2])
                 | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                 | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    assign pg[k] = &p[4*k +: 4];
  end

  assign cg[0] = cin;
  assign cg[1] = gg[0] | (pg[0] & cin);
  assign cg[2] = gg[1] | (pg[1] & gg[0])
               | (pg[1] & pg[0] & cin);
  assign cg[3] = gg[2] | (pg[2] & gg[1])
               | (pg[2] & pg[1] & gg[0])
               | (pg[2] & pg[1] & pg[0] & cin);
  assign cg[4] = gg[3] | (pg[3] & gg[2])
               | (pg[3] & pg[2] & gg[1])
               | (pg[3] & pg[2] & pg[1] & gg[0])
               | (&pg & cin);

  // Bit carries inside each group start from the lookahead group carry.
  always_comb begin
    logic cc;
    c  = '0;
    cc = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cc = cg[k];
      for (int j = 0; j < 4; j++) begin
        c[4*k+j] = cc;
        cc = g[4*k+j] | (p[4*k+j] & cc);
      end
    end
  end

  assign s    = p ^ c;
  assign cout = cg[4];

endmodule

// File: rtl/cla_seq_adder.sv
// cla_seq_adder: streamed LSW-first add/sub around one 16-bit CLA.
// Define CLA_SEQ_OVF_EN to add the signed overflow output.
module cla_seq_adder
  import cla_seq_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MAX_WORDS = 8,
  localparam int CNT_W    = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_words,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_word,
  input  logic [WIDTH-1:0] b_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_word,
  output logic             out_last,
  output logic             carry_out,
`ifdef CLA_SEQ_OVF_EN
  output logic             overflow,
`endif
  output logic             busy,
  output logic             err
);

  if (WIDTH != cla_seq_pkg::WIDTH) begin : g_bad_width
    $error("cla_seq_adder: WIDTH must be 16");
  end

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] len;
  logic [CNT_W-1:0] cnt;
  logic             sub_r;
  logic             carry_reg;
  res_t             out_r;
  logic             out_v;
  logic             err_r;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             legal;
  logic             go;
  logic             acc;
  logic             last;

  assign legal = (num_words != '0)
              && (num_words <= CNT_W'(MAX_WORDS));
  assign go    = (state == IDLE) && start && legal;
  assign in_ready = (state == RUN)
                 && (!out_v || out_ready);
  assign acc   = in_valid && in_ready;
  assign last  = cnt == (len - CNT_W'(1));
  assign b_eff = b_word ^ {WIDTH{sub_r}};

  cla_seq_adder_cla16 u_cla (
    .a    (a_word),
    .b    (b_eff),
    .cin  (carry_reg),
    .s    (s),
    .cout (cout)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (go) state_n = RUN;
      RUN:     if (acc && last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len       <= '0;
      cnt       <= '0;
      sub_r     <= 1'b0;
      carry_reg <= 1'b0;
      out_r     <= '0;
      out_v     <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      err_r <= (state == IDLE) && start && !legal;
      if (go) begin
        len       <= num_words;
        sub_r     <= sub;
        carry_reg <= sub;
        cnt       <= '0;
      end
      // Drain and accept in the same cycle reloads without a bubble.
      if (acc) begin
        out_r.sum  <= s;
        out_r.last <= last;
        carry_reg  <= cout;
        cnt        <= cnt + CNT_W'(1);
        out_v      <= 1'b1;
        if (last) out_r.carry <= cout;
      end else if (out_ready) begin
        out_v <= 1'b0;
      end
    end
  end

`ifdef CLA_SEQ_OVF_EN
  logic c15;
  assign c15 = a_word[WIDTH-1] ^ b_eff[WIDTH-1] ^ s[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst)               overflow <= 1'b0;
    else if (acc && last)  overflow <= cout ^ c15;
  end
`endif

  assign out_valid = out_v;
  assign sum_word  = out_r.sum;
  assign out_last  = out_r.last;
  assign carry_out = out_r.carry;
  assign busy      = (state == RUN) || out_v;
  assign err       = err_r;

endmodule

// File: tb/tb_cla_seq_adder.sv
// tb_cla_seq_adder: random and directed streams checked against
// a wide-integer reference model through a scoreboard queue.
module tb_cla_seq_adder;

  typedef struct {
    logic [15:0] sum;
    bit          last;
    bit          carry;
    bit          ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  num_words;
  logic        sub;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_word;
  logic [15:0] b_word;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum_word;
  logic        out_last;
  logic        carry_out;
  logic        busy;
  logic        err;
`ifdef CLA_SEQ_OVF_EN
  logic        overflow;
`endif

  int   checks = 0;
  int   errors = 0;
  bit   bp_rand = 1'b0;
  exp_t sb[$];

  always #5 clk = ~clk;

  cla_seq_adder dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_words (num_words),
    .sub       (sub),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_word    (a_word),
    .b_word    (b_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_word  (sum_word),
    .out_last  (out_last),
    .carry_out (carry_out),
`ifdef CLA_SEQ_OVF_EN
    .overflow  (overflow),
`endif
    .busy      (busy),
    .err       (err)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: whole operands as wide integers, modulo 2^(16*len).
  task automatic push_exp(input int len, input bit s,
                          input logic [127:0] a,
                          input logic [127:0] b);
    logic [128:0] mask, am, bm, r;
    bit cy, ovf, sa, sb_, sr;
    exp_t e;
    mask = (129'd1 << (16 * len)) - 129'd1;
    am = {1'b0, a} & mask;
    bm = {1'b0, b} & mask;
    if (s) begin
      r  = (am - bm) & mask;
      cy = am >= bm;
    end else begin
      r  = am + bm;
      cy = r > mask;
      r  = r & mask;
    end
    sa  = am[16*len-1];
    sb_ = bm[16*len-1];
    sr  = r[16*len-1];
    ovf = s ? (sa != sb_ && sr != sa) : (sa == sb_ && sr != sa);
    for (int i = 0; i < len; i++) begin
      e.sum   = r[16*i +: 16];
      e.last  = (i == len - 1);
      e.carry = cy;
      e.ovf   = ovf;
      sb.push_back(e);
    end
  endtask

  task automatic start_op(input int len, input bit s,
                          input logic [127:0] a,
                          input logic [127:0] b);
    push_exp(len, s, a, b);
    start = 1'b1;
    num_words = 4'(len);
    sub = s;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed_word(input logic [15:0] a,
                           input logic [15:0] b);
    int t;
    t = 0;
    in_valid = 1'b1;
    a_word = a;
    b_word = b;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 200) begin
        checks++;
        errors++;
        $display("FAIL in_ready_timeout: got 0 expected 1");
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_op(input int len, input bit s,
                        input logic [127:0] a,
                        input logic [127:0] b);
    start_op(len, s, a, b);
    for (int i = 0; i < len; i++)
      feed_word(a[16*i +: 16], b[16*i +: 16]);
  endtask

  task automatic drain();
    int t;
    t = 0;
    bp_rand = 1'b0;
    out_ready = 1'b1;
    while (sb.size() != 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk); #1;
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic illegal(input int n);
    start = 1'b1;
    num_words = 4'(n);
    @(posedge clk); #1;
    start = 1'b0;
    chk("err_pulse", err, 1);
    chk("illegal_busy", busy, 0);
    chk("illegal_in_ready", in_ready, 0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    chk("err_clear", err, 0);
    chk("idle_no_accept", in_ready, 0);
    in_valid = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (bp_rand) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pop on every transfer, and hold-check under backpressure.
  initial begin
    exp_t e;
    bit holding;
    logic [15:0] h_sum;
    logic h_last, h_carry;
    holding = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        holding = 1'b0;
      end else begin
        if (holding && out_valid) begin
          chk("hold_sum", sum_word, h_sum);
          chk("hold_last", out_last, h_last);
          if (h_last) chk("hold_carry", carry_out, h_carry);
        end
        if (out_valid && out_ready) begin
          holding = 1'b0;
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_word: got %0h expected none",
                     sum_word);
          end else begin
            e = sb.pop_front();
            chk("sum_word", sum_word, e.sum);
            chk("out_last", out_last, e.last);
            if (e.last) begin
              chk("carry_out", carry_out, e.carry);
`ifdef CLA_SEQ_OVF_EN
              chk("overflow", overflow, e.ovf);
`endif
            end
          end
        end else if (out_valid) begin
          chk("bp_in_ready", in_ready, 0);
          holding = 1'b1;
          h_sum   = sum_word;
          h_last  = out_last;
          h_carry = carry_out;
        end else begin
          holding = 1'b0;
        end
      end
    end
  end

  initial begin
    logic [127:0] a, b;
    int c;
    rst = 1'b1;
    start = 1'b0;
    num_words = '0;
    sub = 1'b0;
    in_valid = 1'b0;
    a_word = '0;
    b_word = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum_word", sum_word, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_carry_out", carry_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
`ifdef CLA_SEQ_OVF_EN
    chk("rst_overflow", overflow, 0);
`endif
    rst = 1'b0;

    run_op(2, 1'b0, 128'h0001_FFFF, 128'h0000_0001);
    run_op(1, 1'b0, 128'hFFFF, 128'h0001);
    run_op(1, 1'b0, 128'h7FFF, 128'h0001);
    run_op(2, 1'b1, 128'h0001_0000, 128'h0000_0001);
    run_op(1, 1'b1, 128'h0000, 128'h0001);
    run_op(8, 1'b0, {128{1'b1}}, 128'h1);
    drain();

    illegal(0);
    illegal(9);

    // start while running is ignored and raises no err
    fork
      run_op(3, 1'b0, 128'h1234_5678_9ABC, 128'h0FED_CBA9_8765);
      begin
        @(posedge clk);
        @(posedge clk); #2;
        start = 1'b1;
        num_words = 4'd0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("run_start_no_err", err, 0);
        chk("run_busy", busy, 1);
      end
    join
    drain();

    // backpressure: first result held for three cycles
    out_ready = 1'b0;
    fork
      run_op(4, 1'b0, 128'h1111_2222_3333_FFFF,
             128'h0000_0000_0000_0001);
      begin
        c = 0;
        @(negedge clk);
        while (!out_valid && c < 50) begin
          @(negedge clk);
          c++;
        end
        for (int i = 0; i < 3; i++) begin
          chk("bp_hold_in_ready", in_ready, 0);
          chk("bp_hold_valid", out_valid, 1);
          @(posedge clk);
        end
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // reset after two of four words
    a = 128'hAAAA_BBBB_CCCC_DDDD;
    b = 128'h1111_2222_3333_4444;
    start_op(4, 1'b0, a, b);
    feed_word(a[15:0], b[15:0]);
    feed_word(a[31:16], b[31:16]);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    run_op(1, 1'b0, 128'h3, 128'h4);
    drain();

    bp_rand = 1'b1;
    for (int n = 0; n < 40; n++) begin
      a = {$urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom, $urandom};
      case ($urandom_range(0, 3))
        0: b = a;
        1: a = ~128'h0;
        default: ;
      endcase
      run_op($urandom_range(1, 8), 1'($urandom_range(0, 1)), a, b);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
